// File: rtl/mouse_decoder_pkg.sv
// Shared game package: screen geometry, mouse packet FSM states,
// and the axis clamp helper used by the cursor position logic.
package mouse_decoder_pkg;

    localparam int SCREEN_W     = 640;
    localparam int SCREEN_H     = 480;
    localparam int SCREEN_X_MAX = SCREEN_W - 1;
    localparam int SCREEN_Y_MAX = SCREEN_H - 1;

    typedef enum logic [1:0] {
        BYTE0,
        BYTE1,
        BYTE2
    } pkt_state_t;

    function automatic logic [10:0] clamp_axis(
        input logic signed [10:0] v,
        input logic signed [10:0] max
    );
        if (v < 0)
            return 11'd0;
        else if (v > max)
            return max;
        else
            return v;
    endfunction

endpackage

// File: rtl/mouse_decoder_if.sv
// PS/2 input pins and decoded cursor outputs of the mouse decoder.
// master = decoder side, slave = mouse/consumer side.
interface mouse_decoder_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [9:0] x;
    logic [8:0] y;
    logic       click;
    logic       left;
    logic       pkt_valid;

    modport master (
        input  ps2_clk, ps2_data,
        output x, y, click, left, pkt_valid
    );

    modport slave (
        output ps2_clk, ps2_data,
        input  x, y, click, left, pkt_valid
    );
endinterface

// File: rtl/mouse_decoder_ps2_rx_byte.sv
// PS/2 byte receiver: sync, falling-edge sampling, 11-bit framing, idle timeout.
// Parity is enforced only when MOUSE_PARITY_CHECK_EN is defined.
module ps2_rx_byte #(
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       pkt_busy,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       frame_drop,
    output logic       timeout
);

`ifdef MOUSE_PARITY_CHECK_EN
    localparam bit PAR_CHECK = 1'b1;
`else
    localparam bit PAR_CHECK = 1'b0;
`endif

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          clk_prev;
    logic [3:0]    bit_cnt;
    logic [9:0]    shreg;
    logic [TW-1:0] idle_cnt;

    logic fall;
    logic din;
    logic par_odd;
    logic frame_ok;
    logic active;

    // Edge detect and frame validity of the bits collected so far.
    always_comb begin
        fall     = clk_prev & ~clk_sync[1];
        din      = data_sync[1];
        par_odd  = ^shreg[9:1];
        frame_ok = ~shreg[0] & din & (par_odd | ~PAR_CHECK);
        active   = (bit_cnt != 4'd0) | pkt_busy;
    end

    // Synchronizers, bit shifter, byte strobe and idle timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync   <= 2'b11;
            data_sync  <= 2'b11;
            clk_prev   <= 1'b1;
            bit_cnt    <= 4'd0;
            shreg      <= 10'd0;
            idle_cnt   <= '0;
            byte_valid <= 1'b0;
            rx_byte    <= 8'd0;
            frame_drop <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            clk_sync   <= {clk_sync[0], ps2_clk};
            data_sync  <= {data_sync[0], ps2_data};
            clk_prev   <= clk_sync[1];
            byte_valid <= 1'b0;
            frame_drop <= 1'b0;
            timeout    <= 1'b0;
            if (fall) begin
                idle_cnt <= '0;
                if (bit_cnt == 4'd10) begin
                    bit_cnt <= 4'd0;
                    if (frame_ok) begin
                        byte_valid <= 1'b1;
                        rx_byte    <= shreg[8:1];
                    end else begin
                        frame_drop <= 1'b1;
                    end
                end else begin
                    shreg   <= {din, shreg[9:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (active) begin
                if (idle_cnt == TW'(TIMEOUT_CYC - 1)) begin
                    idle_cnt <= '0;
                    bit_cnt  <= 4'd0;
                    timeout  <= 1'b1;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end else begin
                idle_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/mouse_decoder.sv
// PS/2 mouse decoder: 3-byte packet FSM and clamped cursor position.
// Optional parity enforcement: define MOUSE_PARITY_CHECK_EN.
module mouse_decoder
    import mouse_decoder_pkg::*;
#(
    parameter int X_MAX       = SCREEN_X_MAX,
    parameter int Y_MAX       = SCREEN_Y_MAX,
    parameter int TIMEOUT_CYC = 100000
) (
    input logic                clk,
    input logic                reset,
    mouse_decoder_if.master    bus
);

    pkt_state_t state, state_nxt;

    logic       byte_valid;
    logic [7:0] rx_byte;
    logic       frame_drop;
    logic       timeout;
    logic       pkt_busy;

    logic       b0_left, b0_xs, b0_ys, b0_xo, b0_yo;
    logic [7:0] b1_q;

    logic [9:0] x_q, x_nxt;
    logic [8:0] y_q, y_nxt;
    logic       left_q, click_q, pkt_q;
    logic       pkt_done;

    logic [8:0]        dx, dy;
    logic signed [10:0] x_sum, y_sum;

    assign pkt_busy = (state != BYTE0);

    ps2_rx_byte #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clk        (clk),
        .rst_n      (reset),
        .ps2_clk    (bus.ps2_clk),
        .ps2_data   (bus.ps2_data),
        .pkt_busy   (pkt_busy),
        .byte_valid (byte_valid),
        .rx_byte    (rx_byte),
        .frame_drop (frame_drop),
        .timeout    (timeout)
    );

    // Packet state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= BYTE0;
        else
            state <= state_nxt;
    end

    // Next packet state; drops and timeouts abort to BYTE0.
    always_comb begin
        state_nxt = state;
        pkt_done  = 1'b0;
        if (frame_drop || timeout) begin
            state_nxt = BYTE0;
        end else if (byte_valid) begin
            unique case (state)
                BYTE0: if (rx_byte[3]) state_nxt = BYTE1;
                BYTE1: state_nxt = BYTE2;
                BYTE2: begin
                    state_nxt = BYTE0;
                    pkt_done  = 1'b1;
                end
                default: state_nxt = BYTE0;
            endcase
        end
    end

    // Signed movement and clamped new position; overflow freezes an axis.
    always_comb begin
        dx    = {b0_xs, b1_q};
        dy    = {b0_ys, rx_byte};
        x_sum = $signed({1'b0, x_q}) + $signed({{2{dx[8]}}, dx});
        y_sum = $signed({2'b00, y_q}) - $signed({{2{dy[8]}}, dy});
        x_nxt = b0_xo ? x_q : 10'(clamp_axis(x_sum, 11'(X_MAX)));
        y_nxt = b0_yo ? y_q : 9'(clamp_axis(y_sum, 11'(Y_MAX)));
    end

    // Header/byte1 capture and registered cursor outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            b0_left <= 1'b0;
            b0_xs   <= 1'b0;
            b0_ys   <= 1'b0;
            b0_xo   <= 1'b0;
            b0_yo   <= 1'b0;
            b1_q    <= 8'd0;
            x_q     <= 10'(X_MAX / 2);
            y_q     <= 9'(Y_MAX / 2);
            left_q  <= 1'b0;
            click_q <= 1'b0;
            pkt_q   <= 1'b0;
        end else begin
            click_q <= 1'b0;
            pkt_q   <= 1'b0;
            if (byte_valid && state == BYTE0 && rx_byte[3]) begin
                b0_left <= rx_byte[0];
                b0_xs   <= rx_byte[4];
                b0_ys   <= rx_byte[5];
                b0_xo   <= rx_byte[6];
                b0_yo   <= rx_byte[7];
            end
            if (byte_valid && state == BYTE1)
                b1_q <= rx_byte;
            if (pkt_done) begin
                x_q     <= x_nxt;
                y_q     <= y_nxt;
                left_q  <= b0_left;
                click_q <= b0_left & ~left_q;
                pkt_q   <= 1'b1;
            end
        end
    end

    assign bus.x         = x_q;
    assign bus.y         = y_q;
    assign bus.left      = left_q;
    assign bus.click     = click_q;
    assign bus.pkt_valid = pkt_q;

endmodule

// File: tb/tb_mouse_decoder.sv
// Directed bench for mouse_decoder: PS/2 frames driven bit by bit,
// cursor/button outputs checked against hand-computed values.
module tb_mouse_decoder;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;
    int   pkt_cnt = 0;
    int   click_cnt = 0;
    int   pbase;
    int   cbase;

    mouse_decoder_if bus ();

    always #5 clk = ~clk;

    mouse_decoder #(
        .X_MAX       (639),
        .Y_MAX       (479),
        .TIMEOUT_CYC (300)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always @(negedge clk) begin
        if (bus.pkt_valid) pkt_cnt++;
        if (bus.click) click_cnt++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input bit bad_par, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            bus.ps2_data = f[i];
            wait_clk(4);
            bus.ps2_clk = 1'b0;
            wait_clk(4);
            bus.ps2_clk = 1'b1;
        end
        bus.ps2_data = 1'b1;
        wait_clk(6);
    endtask

    task automatic send_pkt(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        send_bits(a, 1'b0, 11);
        send_bits(b, 1'b0, 11);
        send_bits(c, 1'b0, 11);
        wait_clk(12);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        wait_clk(3);
        reset = 1'b1;
        wait_clk(3);
        pbase = pkt_cnt;
        cbase = click_cnt;
    endtask

    initial begin
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        reset = 1'b0;
        wait_clk(3);
        check("rst_x", int'(bus.x), 319);
        check("rst_y", int'(bus.y), 239);
        check("rst_left", int'(bus.left), 0);
        check("rst_click", int'(bus.click), 0);
        check("rst_pkt", int'(bus.pkt_valid), 0);
        reset = 1'b1;
        wait_clk(3);
        pbase = pkt_cnt;
        cbase = click_cnt;

        send_pkt(8'h08, 8'h05, 8'h03);
        check("basic_x", int'(bus.x), 324);
        check("basic_y", int'(bus.y), 236);
        check("basic_pkts", pkt_cnt - pbase, 1);
        check("basic_click", click_cnt - cbase, 0);

        do_reset();
        send_pkt(8'h09, 8'h00, 8'h00);
        check("press_click", click_cnt - cbase, 1);
        check("press_left", int'(bus.left), 1);
        send_pkt(8'h09, 8'h00, 8'h00);
        check("hold_click", click_cnt - cbase, 1);
        check("hold_left", int'(bus.left), 1);
        send_pkt(8'h08, 8'h00, 8'h00);
        check("release_left", int'(bus.left), 0);
        check("release_click", click_cnt - cbase, 1);
        check("btn_pkts", pkt_cnt - pbase, 3);
        check("btn_x", int'(bus.x), 319);

        do_reset();
        send_pkt(8'h18, 8'h00, 8'h00);
        check("dxneg_x1", int'(bus.x), 63);
        send_pkt(8'h18, 8'h00, 8'h00);
        check("dxneg_clamp0", int'(bus.x), 0);
        send_pkt(8'h28, 8'h00, 8'h00);
        check("dyneg_y1", int'(bus.y), 479);
        send_pkt(8'h28, 8'h00, 8'h00);
        check("dyneg_clamp", int'(bus.y), 479);
        check("dyneg_x", int'(bus.x), 0);

        do_reset();
        send_pkt(8'h08, 8'hFF, 8'h00);
        check("dxpos_x1", int'(bus.x), 574);
        send_pkt(8'h08, 8'hFF, 8'h00);
        check("dxpos_clampmax", int'(bus.x), 639);
        send_pkt(8'hC8, 8'h80, 8'h40);
        check("ovf_x", int'(bus.x), 639);
        check("ovf_y", int'(bus.y), 239);
        check("ovf_pkts", pkt_cnt - pbase, 3);

        do_reset();
        send_bits(8'h00, 1'b0, 11);
        send_pkt(8'h08, 8'h02, 8'h02);
        check("resync_pkts", pkt_cnt - pbase, 1);
        check("resync_x", int'(bus.x), 321);
        check("resync_y", int'(bus.y), 237);

        do_reset();
        send_bits(8'h08, 1'b0, 11);
        send_bits(8'h01, 1'b0, 4);
        wait_clk(400);
        send_pkt(8'h08, 8'h01, 8'h01);
        check("tmo_pkts", pkt_cnt - pbase, 1);
        check("tmo_x", int'(bus.x), 320);
        check("tmo_y", int'(bus.y), 238);

        do_reset();
        send_bits(8'h08, 1'b0, 11);
        send_bits(8'h04, 1'b1, 11);
        send_bits(8'h00, 1'b0, 11);
        wait_clk(12);
`ifdef MOUSE_PARITY_CHECK_EN
        check("par_pkts", pkt_cnt - pbase, 0);
        check("par_x", int'(bus.x), 319);
        send_pkt(8'h08, 8'h01, 8'h01);
        check("par_next_x", int'(bus.x), 320);
`else
        check("par_pkts", pkt_cnt - pbase, 1);
        check("par_x", int'(bus.x), 323);
        send_pkt(8'h08, 8'h01, 8'h01);
        check("par_next_x", int'(bus.x), 324);
`endif
        check("par_next_y", int'(bus.y), 238);

        do_reset();
        send_pkt(8'h08, 8'h10, 8'h00);
        check("pre_midrst_x", int'(bus.x), 335);
        send_bits(8'h08, 1'b0, 11);
        send_bits(8'h01, 1'b0, 5);
        reset = 1'b0;
        wait_clk(2);
        check("midrst_x", int'(bus.x), 319);
        check("midrst_y", int'(bus.y), 239);
        reset = 1'b1;
        wait_clk(3);
        pbase = pkt_cnt;
        send_pkt(8'h08, 8'h01, 8'h01);
        check("postrst_pkts", pkt_cnt - pbase, 1);
        check("postrst_x", int'(bus.x), 320);
        check("postrst_y", int'(bus.y), 238);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
